// File: rtl/mpsoc_wb_uart_ctrl.sv
// Wishbone classic master that initialises a 16550-style UART and streams bytes into THR.
// Optional polled receive path is enabled by defining UART_CTRL_RX_EN.
module mpsoc_wb_uart_ctrl #(
   parameter logic [31:0] UART_BASE  = 32'h0000_0000,
   parameter logic [15:0] DIVISOR    = 16'd27,
   parameter logic [7:0]  LCR_VAL    = 8'h03,
   parameter logic [4:0]  FIFO_DEPTH = 5'd16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic [2:0]  wb_cti_o,
   output logic [1:0]  wb_bte_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
`ifdef UART_CTRL_RX_EN
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
`endif
   output logic        init_done_o
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_POLL, S_THR, S_RBR} state_t;

   localparam logic [2:0] IDX_THR   = 3'd0;
   localparam logic [2:0] IDX_LSR   = 3'd5;
   localparam logic [2:0] LAST_STEP = 3'd5;

   state_t     state, state_nx;
   logic [2:0] step, step_nx;
   logic       stb, stb_nx;
   logic       we, we_nx;
   logic [2:0] idx, idx_nx;
   logic [7:0] wdat, wdat_nx;
   logic [4:0] credits, credits_nx;
   logic       done, done_nx;
   logic [7:0] rbyte;
`ifdef UART_CTRL_RX_EN
   logic [7:0] rx_data, rx_data_nx;
   logic       rx_valid, rx_valid_nx;
`endif

   // Init table entry: {register index, byte to write}
   function automatic logic [10:0] init_entry(input logic [2:0] s);
      case (s)
         3'd0:    init_entry = {3'd3, 8'h80 | LCR_VAL};
         3'd1:    init_entry = {3'd0, DIVISOR[7:0]};
         3'd2:    init_entry = {3'd1, DIVISOR[15:8]};
         3'd3:    init_entry = {3'd3, LCR_VAL};
         3'd4:    init_entry = {3'd2, 8'h07};
         default: init_entry = {3'd1, 8'h00};
      endcase
   endfunction

   assign rbyte = wb_dat_i[{idx[1:0], 3'b000} +: 8];

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state    <= S_INIT;
         step     <= 3'd0;
         stb      <= 1'b0;
         we       <= 1'b0;
         idx      <= 3'd0;
         wdat     <= 8'h00;
         credits  <= 5'd0;
         done     <= 1'b0;
`ifdef UART_CTRL_RX_EN
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         step     <= step_nx;
         stb      <= stb_nx;
         we       <= we_nx;
         idx      <= idx_nx;
         wdat     <= wdat_nx;
         credits  <= credits_nx;
         done     <= done_nx;
`ifdef UART_CTRL_RX_EN
         rx_data  <= rx_data_nx;
         rx_valid <= rx_valid_nx;
`endif
      end
   end

   // Accesses are issued only while stb is low, which guarantees the idle cycle after each ack.
   always_comb begin
      state_nx   = state;
      step_nx    = step;
      stb_nx     = stb;
      we_nx      = we;
      idx_nx     = idx;
      wdat_nx    = wdat;
      credits_nx = credits;
      done_nx    = done;
`ifdef UART_CTRL_RX_EN
      rx_data_nx  = rx_data;
      rx_valid_nx = rx_valid;
      if (rx_valid && rx_ready_i) rx_valid_nx = 1'b0;
`endif
      case (state)
         S_INIT: begin
            if (!stb) begin
               stb_nx             = 1'b1;
               we_nx              = 1'b1;
               {idx_nx, wdat_nx}  = init_entry(step);
            end else if (wb_ack_i) begin
               stb_nx = 1'b0;
               if (step == LAST_STEP) begin
                  done_nx  = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  step_nx = step + 3'd1;
               end
            end
         end
         S_IDLE: begin
            if (tx_valid_i && credits != 5'd0) begin
               stb_nx   = 1'b1;
               we_nx    = 1'b1;
               idx_nx   = IDX_THR;
               wdat_nx  = tx_data_i;
               state_nx = S_THR;
            end else if (tx_valid_i) begin
               stb_nx   = 1'b1;
               we_nx    = 1'b0;
               idx_nx   = IDX_LSR;
               wdat_nx  = 8'h00;
               state_nx = S_POLL;
            end
`ifdef UART_CTRL_RX_EN
            else if (!rx_valid) begin
               stb_nx   = 1'b1;
               we_nx    = 1'b0;
               idx_nx   = IDX_LSR;
               wdat_nx  = 8'h00;
               state_nx = S_POLL;
            end
`endif
         end
         S_POLL: begin
            if (stb && wb_ack_i) begin
               stb_nx   = 1'b0;
               state_nx = S_IDLE;
               // THRE means the TX FIFO is empty, so the full depth is available again
               if (rbyte[5]) credits_nx = FIFO_DEPTH;
`ifdef UART_CTRL_RX_EN
               if (rbyte[0] && !rx_valid) state_nx = S_RBR;
`endif
            end
         end
         S_THR: begin
            if (stb && wb_ack_i) begin
               stb_nx   = 1'b0;
               state_nx = S_IDLE;
               if (credits != 5'd0) credits_nx = credits - 5'd1;
            end
         end
`ifdef UART_CTRL_RX_EN
         S_RBR: begin
            if (!stb) begin
               stb_nx  = 1'b1;
               we_nx   = 1'b0;
               idx_nx  = IDX_THR;
               wdat_nx = 8'h00;
            end else if (wb_ack_i) begin
               stb_nx      = 1'b0;
               rx_data_nx  = rbyte;
               rx_valid_nx = 1'b1;
               state_nx    = S_IDLE;
            end
         end
`endif
         default: state_nx = S_INIT;
      endcase
   end

   assign wb_cyc_o    = stb;
   assign wb_stb_o    = stb;
   assign wb_we_o     = stb & we;
   assign wb_adr_o    = stb ? (UART_BASE + {29'd0, idx}) : 32'h0;
   assign wb_dat_o    = (stb && we) ? {4{wdat}} : 32'h0;
   assign wb_sel_o    = stb ? (4'b0001 << idx[1:0]) : 4'b0000;
   assign wb_cti_o    = 3'b000;
   assign wb_bte_o    = 2'b00;
   assign tx_ready_o  = (state == S_THR) && stb && wb_ack_i;
   assign init_done_o = done;
`ifdef UART_CTRL_RX_EN
   assign rx_data_o   = rx_data;
   assign rx_valid_o  = rx_valid;
`endif

endmodule

// File: tb/tb_mpsoc_wb_uart_ctrl.sv
// Bench for mpsoc_wb_uart_ctrl: Wishbone slave model with programmable latency and LSR
// contents, transaction log, and a credit-based reference model of the expected bus traffic.
module tb_mpsoc_wb_uart_ctrl;

   localparam logic [31:0] BASE = 32'h0000_0000;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] adr, dat_o, dat_i;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, init_done;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   txn_t log_q[$];
   int   pulse_q[$];
   txn_t exp_q[$];
   int   exp_p[$];
   int   base, pbase;

   int         lat = 0;
   logic [7:0] lsr_def = 8'h60;
   int         lsr_reads = 0;
   int         zero_until = 0;
   int         cnt;
   int         proto_err = 0;

   int m_credits, m_lsr_n, m_zero;

   logic        p_stb, p_ack, p_we;
   logic [31:0] p_adr, p_dat;
   logic [3:0]  p_sel;

   mpsoc_wb_uart_ctrl dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wb_adr_o    (adr),
      .wb_dat_o    (dat_o),
      .wb_sel_o    (sel),
      .wb_we_o     (we),
      .wb_cyc_o    (cyc),
      .wb_stb_o    (stb),
      .wb_cti_o    (cti),
      .wb_bte_o    (bte),
      .wb_dat_i    (dat_i),
      .wb_ack_i    (ack),
      .tx_data_i   (tx_data),
      .tx_valid_i  (tx_valid),
      .tx_ready_o  (tx_ready),
      .init_done_o (init_done)
   );

   always #5 clk = ~clk;

   // Slave: acks lat+1 cycles after strobe, logs each completed access
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack   <= 1'b0;
         cnt   <= 0;
         dat_i <= 32'h0;
      end else begin
         ack <= 1'b0;
         if (stb && !ack) begin
            if (cnt >= lat) begin
               ack <= 1'b1;
               cnt <= 0;
               log_q.push_back(txn_t'{we, adr, (we ? dat_o : 32'h0), sel});
               if (!we && adr == BASE + 32'd5) begin
                  dat_i <= {24'h0, ((lsr_reads < zero_until) ? 8'h00 : lsr_def)} << {adr[1:0], 3'b000};
                  lsr_reads <= lsr_reads + 1;
               end else begin
                  dat_i <= 32'h0;
               end
            end else begin
               cnt <= cnt + 1;
            end
         end
      end
   end

   // Bus protocol monitor and tx_ready pulse recorder
   always @(negedge clk) begin
      if (!rst_n) begin
         p_stb <= 1'b0;
         p_ack <= 1'b0;
      end else begin
         if (cyc !== stb || cti !== 3'b000 || bte !== 2'b00) proto_err <= proto_err + 1;
         if (stb && p_stb && p_ack) proto_err <= proto_err + 1;
         if (stb && p_stb && !p_ack &&
             (adr !== p_adr || dat_o !== p_dat || sel !== p_sel || we !== p_we))
            proto_err <= proto_err + 1;
         if (tx_ready) pulse_q.push_back(log_q.size());
         p_stb <= stb;
         p_ack <= ack;
         p_adr <= adr;
         p_dat <= dat_o;
         p_sel <= sel;
         p_we  <= we;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic txn_t init_txn(input int s);
      case (s)
         0:       return txn_t'{1'b1, BASE + 32'd3, 32'h83838383, 4'b1000};
         1:       return txn_t'{1'b1, BASE + 32'd0, 32'h1B1B1B1B, 4'b0001};
         2:       return txn_t'{1'b1, BASE + 32'd1, 32'h00000000, 4'b0010};
         3:       return txn_t'{1'b1, BASE + 32'd3, 32'h03030303, 4'b1000};
         4:       return txn_t'{1'b1, BASE + 32'd2, 32'h07070707, 4'b0100};
         default: return txn_t'{1'b1, BASE + 32'd1, 32'h00000000, 4'b0010};
      endcase
   endfunction

   // Reference: each byte needs a credit; with none left, LSR is read until THRE refills to 16
   task automatic model_byte(input logic [7:0] b);
      int guard = 0;
      logic [7:0] lsr;
      while (m_credits == 0 && guard < 50) begin
         exp_q.push_back(txn_t'{1'b0, BASE + 32'd5, 32'h0, 4'b0010});
         lsr = (m_lsr_n < m_zero) ? 8'h00 : lsr_def;
         if (lsr[5]) m_credits = 16;
         m_lsr_n++;
         guard++;
      end
      exp_q.push_back(txn_t'{1'b1, BASE, {4{b}}, 4'b0001});
      exp_p.push_back(base + exp_q.size());
      m_credits--;
   endtask

   task automatic compare_log(input string tag);
      check($sformatf("%s_count", tag), 128'(log_q.size() - base), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
         check($sformatf("%s_txn%0d", tag, i), 128'(log_q[base + i]), 128'(exp_q[i]));
      check($sformatf("%s_pulses", tag), 128'(pulse_q.size() - pbase), 128'(exp_p.size()));
      for (int i = 0; i < exp_p.size() && pbase + i < pulse_q.size(); i++)
         check($sformatf("%s_pulse%0d_pos", tag, i), 128'(pulse_q[pbase + i]), 128'(exp_p[i]));
   endtask

   task automatic reset_init(input int latency);
      bit ok = 0;
      lat      = latency;
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cyc", 128'(cyc), 128'(0));
      check("rst_stb", 128'(stb), 128'(0));
      check("rst_we", 128'(we), 128'(0));
      check("rst_adr", 128'(adr), 128'(0));
      check("rst_dat", 128'(dat_o), 128'(0));
      check("rst_sel", 128'(sel), 128'(0));
      check("rst_done", 128'(init_done), 128'(0));
      check("rst_ready", 128'(tx_ready), 128'(0));
      base      = log_q.size();
      pbase     = pulse_q.size();
      m_credits = 0;
      m_lsr_n   = 0;
      m_zero    = 0;
      zero_until = lsr_reads;
      exp_q.delete();
      exp_p.delete();
      for (int s = 0; s < 6; s++) exp_q.push_back(init_txn(s));
      rst_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (init_done) begin
            ok = 1;
            break;
         end
      end
      tx_valid = 1'b0;
      check("init_timeout", 128'(ok), 128'(1));
      check("init_done_after_6th_ack", 128'(log_q.size() - base), 128'(6));
      repeat (4) @(negedge clk);
      compare_log("init");
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      model_byte(b);
      tx_data  = b;
      tx_valid = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (tx_ready) begin
            ok = 1;
            break;
         end
      end
      check("send_timeout", 128'(ok), 128'(1));
      @(posedge clk);
      #1;
   endtask

   function automatic int count_reads();
      int n = 0;
      for (int i = base; i < log_q.size(); i++)
         if (!log_q[i].we && log_q[i].adr == BASE + 32'd5) n++;
      return n;
   endfunction

   function automatic int count_writes();
      int n = 0;
      for (int i = base + 6; i < log_q.size(); i++)
         if (log_q[i].we && log_q[i].adr == BASE) n++;
      return n;
   endfunction

   initial begin
      bit ok;
      int b2;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Single byte 0x41 with LSR=0x60
      reset_init(0);
      lsr_def = 8'h60;
      send_byte(8'h41);
      tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      compare_log("b41");
      check("b41_lsr_reads", 128'(count_reads()), 128'(1));

      // Stream 20 random bytes, THRE always set, random slave latency
      reset_init(int'($urandom_range(0, 3)));
      lsr_def = 8'h20 | 8'($urandom_range(0, 255)) & 8'hDF | 8'h20;
      for (int i = 0; i < 20; i++) send_byte(8'($urandom));
      tx_valid = 1'b0;
      repeat (6) @(negedge clk);
      compare_log("stream");
      check("stream_lsr_reads", 128'(count_reads()), 128'(2));
      check("stream_thr_writes", 128'(count_writes()), 128'(20));

      // LSR reports no THRE for five polls
      reset_init(1);
      lsr_def    = 8'h20;
      zero_until = lsr_reads + 5;
      m_zero     = 5;
      send_byte(8'($urandom));
      tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      compare_log("poll");
      check("poll_lsr_reads", 128'(count_reads()), 128'(6));

      // Reset asserted while the DLM write waits on a slow ack
      lat   = 7;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      base  = log_q.size();
      rst_n = 1'b1;
      ok = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (log_q.size() - base == 2 && stb && we && adr == BASE + 32'd1) begin
            ok = 1;
            break;
         end
      end
      check("dlm_reach_timeout", 128'(ok), 128'(1));
      check("dlm_pre0", 128'(log_q[base]), 128'(init_txn(0)));
      check("dlm_pre1", 128'(log_q[base + 1]), 128'(init_txn(1)));
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cyc", 128'(cyc), 128'(0));
      check("midrst_stb", 128'(stb), 128'(0));
      check("midrst_no_dlm_ack", 128'(log_q.size() - base), 128'(2));
      check("midrst_done", 128'(init_done), 128'(0));
      repeat (2) @(negedge clk);
      b2    = log_q.size();
      rst_n = 1'b1;
      ok = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (log_q.size() > b2) begin
            ok = 1;
            break;
         end
      end
      check("restart_timeout", 128'(ok), 128'(1));
      if (ok) check("restart_lcr83", 128'(log_q[b2]), 128'(init_txn(0)));
      ok = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (init_done) begin
            ok = 1;
            break;
         end
      end
      check("restart_init_done", 128'(ok), 128'(1));
      check("restart_init_count", 128'(log_q.size() - b2), 128'(6));

      check("bus_protocol", 128'(proto_err), 128'(0));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
